// File: rtl/cic_pdm_decimator_if.sv
// Purpose: PDM strobe/bits into the CIC decimator, decimated signed samples out.
// Latency: wiring only, no registers.
// Backpressure: none; the sink must take every dout_valid pulse.
interface cic_pdm_decimator_if #(
  parameter int CHANNELS = 4,
  parameter int OUT_SIZE = 8
);
  logic                         ena;
  logic [CHANNELS-1:0]          din;
  logic [CHANNELS*OUT_SIZE-1:0] dout;
  logic                         dout_valid;

  // master = PDM front end / consumer side, slave = the decimator itself
  modport master (output ena, output din, input dout, input dout_valid);
  modport slave  (input ena, input din, output dout, output dout_valid);
endinterface

// File: rtl/cic_pdm_decimator.sv
// Purpose: multi-channel ORDER-stage CIC decimator (rate DECIM) for 1-bit PDM, scaled and saturated.
// Latency: dout/dout_valid update ORDER+1 clk edges after the capturing ena edge.
// Backpressure: none; output is a one-cycle valid pulse, dout holds between pulses.
module cic_pdm_decimator #(
  parameter int CHANNELS = 4,
  parameter int ORDER    = 4,
  parameter int DECIM    = 16,
  parameter int OUT_SIZE = 8,
  parameter int SHIFT    = ORDER * $clog2(DECIM) + 2 - OUT_SIZE
) (
  input logic                clk,
  input logic                rst,
  cic_pdm_decimator_if.slave bus
);

  localparam int ACC_W  = ORDER * $clog2(DECIM) + 2;
  localparam int CNT_W  = $clog2(DECIM);
  localparam int WARM_W = $clog2(ORDER + 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_HI = {{(ACC_W-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam acc_t SAT_LO = {{(ACC_W-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};

  if (ORDER < 1 || ORDER > 6) begin : g_bad_order
    $error("cic_pdm_decimator: ORDER must be in 1..6");
  end
  if (DECIM < ORDER + 2) begin : g_bad_decim
    $error("cic_pdm_decimator: DECIM must be >= ORDER+2 so the comb pipeline drains between captures");
  end
  if (OUT_SIZE >= ACC_W) begin : g_bad_out_size
    $error("cic_pdm_decimator: OUT_SIZE must be narrower than the internal accumulator");
  end
  if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_shift
    $error("cic_pdm_decimator: SHIFT must be in 0..ACC_W-1");
  end

  logic [CNT_W-1:0]             dec_cnt;
  logic                         capture;
  acc_t                         integ     [CHANNELS][ORDER];
  acc_t                         integ_nxt [CHANNELS][ORDER];
  acc_t                         pipe      [CHANNELS][ORDER+1];
  acc_t                         dly       [CHANNELS][ORDER];
  acc_t                         scaled    [CHANNELS];
  logic [ORDER:0]               stage_vld;
  logic [WARM_W-1:0]            warm_cnt;
  logic [CHANNELS*OUT_SIZE-1:0] sat_dat;
  logic [CHANNELS*OUT_SIZE-1:0] dout_q;
  logic                         dout_valid_q;

  // The last strobe of each DECIM-long block is the decimation point.
  assign capture = bus.ena && (dec_cnt == CNT_W'(DECIM - 1));

  // Next integrator values: stage 0 adds the +/-1 PDM bit, stage k adds stage k-1's registered sum.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      integ_nxt[c][0] = integ[c][0] + (bus.din[c] ? acc_t'(1) : acc_t'(-1));
      for (int k = 1; k < ORDER; k++) begin
        integ_nxt[c][k] = integ[c][k] + integ[c][k-1];
      end
    end
  end

  // Decimation counter advances only on PDM strobes and wraps at DECIM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (bus.ena) begin
      dec_cnt <= capture ? '0 : dec_cnt + 1'b1;
    end
  end

  // Integrator chain; wraps modulo 2^ACC_W by design, which the combs undo exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ[c][k] <= '0;
        end
      end
    end else if (bus.ena) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ[c][k] <= integ_nxt[c][k];
        end
      end
    end
  end

  // Capture register plus comb stages: a sample moves one stage per clk; delays move only with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s <= ORDER; s++) begin
          pipe[c][s] <= '0;
        end
        for (int k = 0; k < ORDER; k++) begin
          dly[c][k] <= '0;
        end
      end
    end else begin
      stage_vld <= {stage_vld[ORDER-1:0], capture};
      for (int c = 0; c < CHANNELS; c++) begin
        if (capture) begin
          pipe[c][0] <= integ_nxt[c][ORDER-1];
        end
        for (int k = 0; k < ORDER; k++) begin
          if (stage_vld[k]) begin
            pipe[c][k+1] <= pipe[c][k] - dly[c][k];
            dly[c][k]    <= pipe[c][k];
          end
        end
      end
    end
  end

  // Scale the final comb output and clamp it into the signed OUT_SIZE range.
  always_comb begin
    sat_dat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      scaled[c] = pipe[c][ORDER] >>> SHIFT;
      if (scaled[c] > SAT_HI) begin
        sat_dat[c*OUT_SIZE +: OUT_SIZE] = SAT_HI[OUT_SIZE-1:0];
      end else if (scaled[c] < SAT_LO) begin
        sat_dat[c*OUT_SIZE +: OUT_SIZE] = SAT_LO[OUT_SIZE-1:0];
      end else begin
        sat_dat[c*OUT_SIZE +: OUT_SIZE] = scaled[c][OUT_SIZE-1:0];
      end
    end
  end

  // Output register: the first ORDER samples after reset only prime the comb delays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (stage_vld[ORDER]) begin
        if (warm_cnt == WARM_W'(ORDER)) begin
          dout_q       <= sat_dat;
          dout_valid_q <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
